// File: rtl/seq_rightshifter.sv
// ---------------------------------------------------------------------------
// seq_rightshifter
// Sequential right shifter that moves the operand one bit position per clock.
// A request accepted in IDLE latches the operand, distance and fill mode.
// SHIFT then runs one step per cycle. DONE gives a one-cycle completion pulse.
//
// Ports:
//   CLK      - clock, all state changes on the rising edge
//   RST_N    - asynchronous active-low reset
//   start    - request, only looked at while idle
//   in       - operand to shift right (WIDTH bits)
//   amt      - shift distance in bit positions (AMT_W bits)
//   arith    - 1 = sign fill, 0 = zero fill
//   busy     - high in SHIFT and DONE
//   done     - one-cycle completion pulse (DONE state)
//   out      - result register, intermediate values while shifting
//   out_lsb  - last bit shifted out of out
// ---------------------------------------------------------------------------
module seq_rightshifter #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [AMT_W-1:0] amt,
    input  logic             arith,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             out_lsb
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shiftReg_q, shiftReg_d;
    logic               carry_q, carry_d;
    logic [AMT_W-1:0]   count_q, count_d;
    logic               arith_q, arith_d;

    // Register bank. Reset clears everything, so an aborted operation leaves no trace.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            carry_q    <= 1'b0;
            count_q    <= '0;
            arith_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            carry_q    <= carry_d;
            count_q    <= count_d;
            arith_q    <= arith_d;
        end
    end

    // Next-state logic. Holding every register by default keeps the result
    // stable through DONE and IDLE. Inputs are only consumed in IDLE.
    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        carry_d    = carry_q;
        count_d    = count_q;
        arith_d    = arith_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shiftReg_d = in;
                    count_d    = amt;
                    arith_d    = arith;
                    carry_d    = 1'b0;
                    // A zero distance has nothing to shift, so the pulse
                    // follows the accepting edge directly.
                    state_d    = (amt != '0) ? SHIFT : DONE;
                end
            end

            SHIFT: begin
                // The MSB is reused as fill, so sign fill replicates the
                // originally latched sign on every step.
                shiftReg_d = {arith_q & shiftReg_q[WIDTH-1], shiftReg_q[WIDTH-1:1]};
                carry_d    = shiftReg_q[0];
                count_d    = count_q - AMT_W'(1);
                // Leave on the edge that performs the last shift.
                if (count_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the registered state only.
    always_comb begin
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        out     = shiftReg_q;
        out_lsb = carry_q;
    end

endmodule

// File: tb/tb_seq_rightshifter.sv
// ---------------------------------------------------------------------------
// tb_seq_rightshifter
// Self-checking bench for seq_rightshifter (WIDTH=16, AMT_W=4).
// The expected results come from plain shift arithmetic on the operand:
// >> for zero fill and >>> for sign fill.
// Latency and busy length are derived from the distance.
// ---------------------------------------------------------------------------
module tb_seq_rightshifter;

    localparam int WIDTH = 16;
    localparam int AMT_W = 4;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] inData = '0;
    logic [AMT_W-1:0] amt = '0;
    logic             arith = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] outData;
    logic             out_lsb;

    int total = 0;
    int bad = 0;

    seq_rightshifter #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .start   (start),
        .in      (inData),
        .amt     (amt),
        .arith   (arith),
        .busy    (busy),
        .done    (done),
        .out     (outData),
        .out_lsb (out_lsb)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference result: a whole-word shift of the operand.
    function automatic logic [WIDTH-1:0] modelOut(input logic [WIDTH-1:0] v, input int n, input logic a);
        if (a) return WIDTH'($signed(v) >>> n);
        else   return v >> n;
    endfunction

    // The last bit shifted out is bit n-1 of the original operand.
    function automatic logic modelLsb(input logic [WIDTH-1:0] v, input int n);
        if (n == 0) return 1'b0;
        else        return v[n-1];
    endfunction

    // Called at a falling edge. Starts one operation and scrambles the inputs
    // after the accepting edge. It then waits, with a bound, for the done pulse.
    // It returns the latency counted from the accepting edge and the result.
    task automatic applyStimulus(input logic [WIDTH-1:0] opIn, input logic [AMT_W-1:0] opAmt,
                                 input logic opArith, output int lat,
                                 output logic [WIDTH-1:0] res, output logic resLsb,
                                 output int busyCycles);
        start  = 1'b1;
        inData = opIn;
        amt    = opAmt;
        arith  = opArith;
        @(posedge CLK);
        #1;
        start  = 1'b0;
        inData = WIDTH'($urandom);
        amt    = AMT_W'($urandom);
        arith  = 1'($urandom);
        lat        = -1;
        busyCycles = 0;
        res        = 'x;
        resLsb     = 1'bx;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (busy === 1'b1) busyCycles++;
            if (done === 1'b1) begin
                lat    = c;
                res    = outData;
                resLsb = out_lsb;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #1 RST_N = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        total++;
        if (outData !== '0 || out_lsb !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_values: out=%h lsb=%b busy=%b done=%b, required all zero",
                     outData, out_lsb, busy, done);
        end
        RST_N = 1'b1;
        @(negedge CLK);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || outData !== '0) begin
            bad++;
            $display("[TB] FAIL reset_release_idle: busy=%b done=%b out=%h, required 0 0 0000",
                     busy, done, outData);
        end
    endtask

    task automatic test_directed;
        logic [WIDTH-1:0] vIn  [5] = '{16'hF0F0, 16'h8001, 16'h1234, 16'h8000, 16'h8000};
        logic [AMT_W-1:0] vAmt [5] = '{4'd4, 4'd1, 4'd0, 4'd15, 4'd15};
        logic             vAr  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [WIDTH-1:0] vOut [5] = '{16'h0F0F, 16'hC000, 16'h1234, 16'hFFFF, 16'h0001};
        logic             vLsb [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        int lat, bc;
        logic [WIDTH-1:0] res;
        logic rl;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            applyStimulus(vIn[i], vAmt[i], vAr[i], lat, res, rl, bc);
            total++;
            if (lat !== int'(vAmt[i])) begin
                bad++;
                $display("[TB] FAIL directed_latency[%0d]: got %0d, required %0d", i, lat, vAmt[i]);
            end
            total++;
            if (res !== vOut[i] || rl !== vLsb[i]) begin
                bad++;
                $display("[TB] FAIL directed_result[%0d]: out=%h lsb=%b, required out=%h lsb=%b",
                         i, res, rl, vOut[i], vLsb[i]);
            end
            total++;
            if (bc !== int'(vAmt[i]) + 1) begin
                bad++;
                $display("[TB] FAIL directed_busy_len[%0d]: got %0d, required %0d", i, bc, int'(vAmt[i]) + 1);
            end
            @(negedge CLK);
            total++;
            if (busy !== 1'b0 || done !== 1'b0 || outData !== vOut[i] || out_lsb !== vLsb[i]) begin
                bad++;
                $display("[TB] FAIL directed_idle_hold[%0d]: busy=%b done=%b out=%h lsb=%b, required 0 0 %h %b",
                         i, busy, done, outData, out_lsb, vOut[i], vLsb[i]);
            end
        end
    endtask

    task automatic test_start_held;
        int doneCount = 0;
        int lat = -1;
        logic [WIDTH-1:0] res = 'x;
        logic rl = 1'bx;
        logic [WIDTH-1:0] exp2;
        @(negedge CLK);
        start  = 1'b1;
        inData = 16'h00FF;
        amt    = 4'd3;
        arith  = 1'b0;
        @(posedge CLK);
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            if (done === 1'b1) begin
                doneCount++;
                if (lat < 0) begin
                    lat = c;
                    res = outData;
                    rl  = out_lsb;
                end
            end
            if (c < 3) begin
                inData = WIDTH'($urandom);
                amt    = AMT_W'($urandom);
                arith  = 1'($urandom);
            end else begin
                inData = 16'hA5A5;
                amt    = 4'd2;
                arith  = 1'b1;
            end
        end
        total++;
        if (doneCount !== 1 || lat !== 3) begin
            bad++;
            $display("[TB] FAIL held_start_done: count=%0d latency=%0d, required 1 and 3", doneCount, lat);
        end
        total++;
        if (res !== 16'h001F || rl !== 1'b1) begin
            bad++;
            $display("[TB] FAIL held_start_result: out=%h lsb=%b, required 001f 1", res, rl);
        end
        @(negedge CLK);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL held_start_idle_gap: busy=%b done=%b, required 0 0", busy, done);
        end
        @(posedge CLK);
        #1 start = 1'b0;
        lat = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (done === 1'b1) begin
                lat = c;
                res = outData;
                rl  = out_lsb;
                break;
            end
        end
        exp2 = modelOut(16'hA5A5, 2, 1'b1);
        total++;
        if (lat !== 2 || res !== exp2 || rl !== modelLsb(16'hA5A5, 2)) begin
            bad++;
            $display("[TB] FAIL held_start_second: latency=%0d out=%h lsb=%b, required 2 %h %b",
                     lat, res, rl, exp2, modelLsb(16'hA5A5, 2));
        end
    endtask

    task automatic test_back_to_back;
        int lat, bc, gap;
        logic [WIDTH-1:0] res, v, prevOut, expOut;
        logic rl, a, prevLsb, expLsb;
        logic [AMT_W-1:0] n;
        prevOut = 16'h001F;
        prevLsb = modelLsb(16'hA5A5, 2);
        prevOut = modelOut(16'hA5A5, 2, 1'b1);
        for (int i = 0; i < 40; i++) begin
            v = WIDTH'($urandom);
            a = 1'($urandom);
            n = AMT_W'($urandom);
            if (i == 0) n = '0;
            if (i == 1) n = '1;
            if (i == 2) begin
                v = 16'h8000 | v;
                a = 1'b1;
                n = '1;
            end
            gap = $urandom_range(0, 2);
            for (int g = 0; g <= gap; g++) begin
                @(negedge CLK);
                total++;
                if (busy !== 1'b0 || outData !== prevOut || out_lsb !== prevLsb) begin
                    bad++;
                    $display("[TB] FAIL b2b_idle[%0d]: busy=%b out=%h lsb=%b, required 0 %h %b",
                             i, busy, outData, out_lsb, prevOut, prevLsb);
                end
            end
            applyStimulus(v, n, a, lat, res, rl, bc);
            expOut = modelOut(v, int'(n), a);
            expLsb = modelLsb(v, int'(n));
            total++;
            if (lat !== int'(n) || res !== expOut || rl !== expLsb || bc !== int'(n) + 1) begin
                bad++;
                $display("[TB] FAIL b2b_op[%0d] in=%h amt=%0d arith=%b: lat=%0d out=%h lsb=%b busy=%0d, required %0d %h %b %0d",
                         i, v, n, a, lat, res, rl, bc, n, expOut, expLsb, int'(n) + 1);
            end
            prevOut = expOut;
            prevLsb = expLsb;
        end
    endtask

    task automatic test_reset_midop;
        int lat, bc;
        int doneCount = 0;
        logic [WIDTH-1:0] res, v;
        logic rl;
        @(negedge CLK);
        start  = 1'b1;
        inData = 16'hBEEF;
        amt    = 4'd8;
        arith  = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        total++;
        if (outData !== '0 || out_lsb !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midop_reset_async: out=%h lsb=%b busy=%b done=%b, required all zero",
                     outData, out_lsb, busy, done);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (done === 1'b1) doneCount++;
            if (c == 3) RST_N = 1'b1;
        end
        total++;
        if (doneCount !== 0) begin
            bad++;
            $display("[TB] FAIL midop_no_done: pulses=%0d, required 0", doneCount);
        end
        RST_N = 1'b0;
        #1;
        @(negedge CLK);
        RST_N = 1'b1;
        v = 16'h8C31;
        applyStimulus(v, 4'd5, 1'b1, lat, res, rl, bc);
        total++;
        if (lat !== 5 || res !== modelOut(v, 5, 1'b1) || rl !== modelLsb(v, 5)) begin
            bad++;
            $display("[TB] FAIL midop_recover: lat=%0d out=%h lsb=%b, required 5 %h %b",
                     lat, res, rl, modelOut(v, 5, 1'b1), modelLsb(v, 5));
        end
    endtask

    initial begin
        $display("[TB] starting seq_rightshifter bench");
        test_reset();
        test_directed();
        test_start_held();
        test_back_to_back();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_rightshifter.md
SEQ_RIGHTSHIFTER -- requirements
Module: seq_rightshifter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the data operand width in bits.
REQ-002 SHALL have parameter AMT_W, default 4, giving the shift-amount width; the maximum shift is 2^AMT_W-1.
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on the rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port in  input  WIDTH  operand to shift right.
REQ-007 SHALL have port amt  input  AMT_W  shift distance in bit positions.
REQ-008 SHALL have port arith  input  1  1 = arithmetic (sign-fill), 0 = logical (zero-fill).
REQ-009 SHALL have port busy  output  1  high while an operation is in progress (SHIFT or DONE).
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port out  output  WIDTH  result register.
REQ-012 SHALL have port out_lsb  output  1  last bit shifted out (carry).

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-014 SHALL, in IDLE with start=1 at edge k, latch in into out, latch amt into the counter, latch arith, and clear out_lsb.
REQ-015 SHALL, at that edge k, go to SHIFT if amt!=0, or go directly to DONE if amt==0.
REQ-016 SHALL, in SHIFT, on each edge shift out right by one bit: out_lsb<=out[0]; MSB fill is out[WIDTH-1] if arith was latched as 1, else 0; counter decrements.
REQ-017 SHALL go from SHIFT to DONE on the edge that performs the final (amt-th) shift, so done is high in the cycle following edge k+amt for every amt, 0 included.
REQ-018 SHALL hold done=1 for exactly one cycle in DONE, then return to IDLE unconditionally.
REQ-019 SHALL drive busy=1 in SHIFT and DONE and busy=0 in IDLE (Moore outputs, registered state only).
REQ-020 SHALL ignore start, in, amt and arith while busy=1; latched values are never altered mid-operation.
REQ-021 SHALL allow intermediate values on out during SHIFT; out and out_lsb SHALL be final while done=1 and held unchanged in IDLE until the next accepted start.
REQ-022 SHALL fill with the latched sign bit for every shift when arith=1, so a negative operand saturates at all-ones for large amt.
REQ-023 SHALL accept a new start in the IDLE cycle immediately after DONE (back-to-back spacing amt+2 cycles from start edge to next start edge).

Reset
REQ-024 SHALL, while RST_N=0, asynchronously force state=IDLE, out=0, out_lsb=0, counter=0, busy=0, done=0.
REQ-025 SHALL, on reset asserted mid-operation, abort with no done pulse; the first rising CLK edge after RST_N rises SHALL be able to accept start.

Verification
REQ-026 SHALL cover: WIDTH=16, in=0xF0F0, amt=4, arith=0 -> done in cycle after edge k+4, out=0x0F0F, out_lsb=0, busy high for 5 cycles.
REQ-027 SHALL cover: in=0x8001, amt=1, arith=1 -> done after edge k+1, out=0xC000, out_lsb=1.
REQ-028 SHALL cover: in=0x1234, amt=0 -> done in cycle after edge k, out=0x1234, out_lsb=0.
REQ-029 SHALL cover: in=0x8000, amt=15 -> arith=1 gives out=0xFFFF, out_lsb=0; arith=0 gives out=0x0001, out_lsb=0.
REQ-030 SHALL cover: start held high with changing in/amt during an operation on 0x00FF, amt=3, logical -> single done, out=0x001F, out_lsb=1; a second operation starts only from IDLE.
REQ-031 SHALL cover: RST_N pulsed low at SHIFT step 2 of amt=8 -> outputs immediately 0, no done; a fresh operation after release completes correctly.
